// File: rtl/cordic_post.sv
// cordic_post: CORDIC output stage. Removes the CORDIC gain, rounds/saturates to Q7.8
// and presents results on a valid/ready interface. Macro CORDIC_POST_ROUND_EN selects rounding.
module cordic_post #(
    parameter logic [16:0] GAIN_K = 17'h09B75,
    parameter int          DW_IN  = 24,
    parameter int          DW_OUT = 16,
    parameter int          CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW_IN-1:0]  x_in,
    input  logic [DW_IN-1:0]  y_in,
    input  logic [DW_IN-1:0]  z_in,
    input  logic [3:0]        select_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DW_OUT-1:0] res_a,
    output logic [DW_OUT-1:0] res_b,
    output logic [3:0]        select_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  sat_count
);

    localparam int PW = DW_IN + 18;
`ifdef CORDIC_POST_ROUND_EN
    // Keep one extra fraction bit so S2 can add the half-LSB before dropping it.
    localparam int LSB = 15;
`else
    localparam int LSB = 16;
`endif
    localparam int QW = PW - LSB;
    localparam int RW = PW - 16;

    localparam logic signed [RW-1:0] MAX_R = $signed({{(RW-DW_OUT+1){1'b0}}, {(DW_OUT-1){1'b1}}});
    localparam logic signed [RW-1:0] MIN_R = $signed({{(RW-DW_OUT+1){1'b1}}, {(DW_OUT-1){1'b0}}});

    function automatic logic signed [RW-1:0] descale(input logic [QW-1:0] q);
`ifdef CORDIC_POST_ROUND_EN
        logic [QW-1:0] t;
        t = q + {{(QW-1){1'b0}}, 1'b1};
        return $signed(t[QW-1:1]);
`else
        return $signed(q);
`endif
    endfunction

    // Returns {saturated_flag, clipped_word}.
    function automatic logic [DW_OUT:0] clip(input logic signed [RW-1:0] r);
        if (r > MAX_R)
            return {1'b1, 1'b0, {(DW_OUT-1){1'b1}}};
        else if (r < MIN_R)
            return {1'b1, 1'b1, {(DW_OUT-1){1'b0}}};
        else
            return {1'b0, r[DW_OUT-1:0]};
    endfunction

    logic                     advance;
    logic signed [PW-1:0]     x_ext;
    logic signed [PW-1:0]     y_ext;
    logic signed [PW-1:0]     k_ext;
    logic signed [PW-1:0]     prod_x;
    logic signed [PW-1:0]     prod_y;

    logic                     v1;
    logic [3:0]               sel1;
    logic [QW-1:0]            qx1;
    logic [QW-1:0]            qy1;
    logic [DW_IN-1:0]         z1;

    logic signed [RW-1:0]     rx;
    logic signed [RW-1:0]     ry;
    logic signed [RW-1:0]     rz;
    logic signed [RW-1:0]     rb;
    logic [DW_OUT:0]          clip_a;
    logic [DW_OUT:0]          clip_b;

    logic                     v2;
    logic [3:0]               sel2;
    logic [DW_OUT-1:0]        a2;
    logic [DW_OUT-1:0]        b2;
    logic                     sat2;

    // The whole pipe moves in lockstep; a stalled output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign x_ext  = $signed({{(PW-DW_IN){x_in[DW_IN-1]}}, x_in});
    assign y_ext  = $signed({{(PW-DW_IN){y_in[DW_IN-1]}}, y_in});
    assign k_ext  = $signed({{(PW-17){1'b0}}, GAIN_K});
    assign prod_x = x_ext * k_ext;
    assign prod_y = y_ext * k_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            sel1 <= '0;
            qx1  <= '0;
            qy1  <= '0;
            z1   <= '0;
        end else if (advance) begin
            v1   <= in_valid;
            sel1 <= select_in;
            qx1  <= QW'(prod_x >>> LSB);
            qy1  <= QW'(prod_y >>> LSB);
            z1   <= z_in;
        end
    end

    // Vectoring reports the residual angle directly, without gain compensation.
    always_comb begin
        rx     = descale(qx1);
        ry     = descale(qy1);
        rz     = $signed({{(RW-DW_IN){z1[DW_IN-1]}}, z1});
        rb     = sel1[3] ? rz : ry;
        clip_a = clip(rx);
        clip_b = clip(rb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            sel2 <= '0;
            a2   <= '0;
            b2   <= '0;
            sat2 <= 1'b0;
        end else if (advance) begin
            v2   <= v1;
            sel2 <= sel1;
            a2   <= clip_a[DW_OUT-1:0];
            b2   <= clip_b[DW_OUT-1:0];
            sat2 <= clip_a[DW_OUT] || clip_b[DW_OUT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            select_out <= '0;
            res_a      <= '0;
            res_b      <= '0;
        end else if (advance) begin
            out_valid  <= v2;
            select_out <= sel2;
            res_a      <= a2;
            res_b      <= b2;
        end
    end

    // One count per saturated word as it enters the output register; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_count <= '0;
        else if (advance && v2 && sat2 && !(&sat_count))
            sat_count <= sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_cordic_post.sv
// tb_cordic_post: scoreboard bench for cordic_post with directed, hand-computed vectors.
// Expected values follow CORDIC_POST_ROUND_EN the same way the design does.
module tb_cordic_post;

    logic        clk;
    logic        rst;
    logic [23:0] x_in;
    logic [23:0] y_in;
    logic [23:0] z_in;
    logic [3:0]  select_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] res_a;
    logic [15:0] res_b;
    logic [3:0]  select_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  sat_count;

    typedef struct {
        int         id;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sel;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         passes = 0;
    int         word_id = 0;
    logic [7:0] exp_sat = 8'd0;

`ifdef CORDIC_POST_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif
    localparam logic [15:0] ONE_K     = ROUND ? 16'h0100 : 16'h00FF;
    localparam logic [15:0] NEG_ONE_K = ROUND ? 16'hFF65 : 16'hFF64;

    cordic_post dut (
        .clk        (clk),
        .rst        (rst),
        .x_in       (x_in),
        .y_in       (y_in),
        .z_in       (z_in),
        .select_in  (select_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .res_a      (res_a),
        .res_b      (res_b),
        .select_out (select_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat_count  (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z,
                                 input logic [3:0] sel, input logic [15:0] ea, input logic [15:0] eb,
                                 input bit sat);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        x_in      = x;
        y_in      = y;
        z_in      = z;
        select_in = sel;
        in_valid  = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        compare_val($sformatf("w%0d.accept", word_id), {31'b0, in_ready}, 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        if (sat && exp_sat != 8'hFF)
            exp_sat++;
        e.id  = word_id;
        e.a   = ea;
        e.b   = eb;
        e.sel = sel;
        e.cnt = exp_sat;
        sb_q.push_back(e);
        word_id++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            compare_val("unexpected_output.out_valid", {31'b0, out_valid}, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        compare_val($sformatf("w%0d.res_a", e.id), {16'b0, res_a}, {16'b0, e.a});
        compare_val($sformatf("w%0d.res_b", e.id), {16'b0, res_b}, {16'b0, e.b});
        compare_val($sformatf("w%0d.select_out", e.id), {28'b0, select_out}, {28'b0, e.sel});
        compare_val($sformatf("w%0d.sat_count", e.id), {24'b0, sat_count}, {24'b0, e.cnt});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        compare_val({name, ".drain"}, sb_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: a transfer seen at this negedge completes on the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (out_ready)
                    checkOutput();
                else
                    compare_val("stall.in_ready", {31'b0, in_ready}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        select_in = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        compare_val("reset.out_valid", {31'b0, out_valid}, 32'd0);
        compare_val("reset.res_a", {16'b0, res_a}, 32'd0);
        compare_val("reset.res_b", {16'b0, res_b}, 32'd0);
        compare_val("reset.select_out", {28'b0, select_out}, 32'd0);
        compare_val("reset.sat_count", {24'b0, sat_count}, 32'd0);
        compare_val("reset.in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        $display("[TB] single words and latency");
        applyStimulus(24'h0001A5, 24'h000000, 24'h000000, 4'b0001, ONE_K, 16'h0000, 1'b0);
        @(negedge clk);
        compare_val("latency.c1", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        compare_val("latency.c2", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        compare_val("latency.c3", {31'b0, out_valid}, 32'd1);
        wait_drain("t1");

        applyStimulus(24'hFFFE5B, 24'h0001A5, 24'h000000, 4'b0010, 16'hFF00, ONE_K, 1'b0);
        applyStimulus(24'h0001A5, 24'h7FFFFF, 24'h00002D, 4'b1000, ONE_K, 16'h002D, 1'b0);
        applyStimulus(24'h7FFFFF, 24'h000000, 24'h000000, 4'b0000, 16'h7FFF, 16'h0000, 1'b1);
        applyStimulus(24'h800000, 24'h000000, 24'h000000, 4'b0000, 16'h8000, 16'h0000, 1'b1);
        wait_drain("singles");

        $display("[TB] stream with mid-stream backpressure");
        fork
            begin
                applyStimulus(24'h000000, 24'h000100, 24'h000000, 4'b0100, 16'h0000, 16'h009B, 1'b0);
                applyStimulus(24'h000000, 24'hFFFF00, 24'h000000, 4'b0101, 16'h0000, NEG_ONE_K, 1'b0);
                applyStimulus(24'h000000, 24'h000000, 24'h007FFF, 4'b1001, 16'h0000, 16'h7FFF, 1'b0);
                applyStimulus(24'h000000, 24'h000000, 24'h008000, 4'b1010, 16'h0000, 16'h7FFF, 1'b1);
                applyStimulus(24'h000000, 24'h000000, 24'hFF8000, 4'b1011, 16'h0000, 16'h8000, 1'b0);
                applyStimulus(24'h000100, 24'h000000, 24'hFF7FFF, 4'b1111, 16'h009B, 16'h8000, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        wait_drain("stream");

        $display("[TB] reset with words in flight");
        out_ready = 1'b0;
        applyStimulus(24'h7FFFFF, 24'h000000, 24'h000000, 4'b0011, 16'h7FFF, 16'h0000, 1'b1);
        applyStimulus(24'h0001A5, 24'h000000, 24'h000000, 4'b0110, ONE_K, 16'h0000, 1'b0);
        applyStimulus(24'h000000, 24'h000100, 24'h000000, 4'b0111, 16'h0000, 16'h009B, 1'b0);
        @(negedge clk);
        compare_val("pre_rst.sat_count", {24'b0, sat_count}, {24'b0, exp_sat});
        #2 rst = 1'b1;
        #1;
        compare_val("mid_rst.out_valid", {31'b0, out_valid}, 32'd0);
        compare_val("mid_rst.sat_count", {24'b0, sat_count}, 32'd0);
        compare_val("mid_rst.res_a", {16'b0, res_a}, 32'd0);
        compare_val("mid_rst.select_out", {28'b0, select_out}, 32'd0);
        sb_q.delete();
        exp_sat = 8'd0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compare_val($sformatf("post_rst.idle%0d", i), {31'b0, out_valid}, 32'd0);
        end

        applyStimulus(24'h0001A5, 24'hFFFF00, 24'h000000, 4'b0001, ONE_K, NEG_ONE_K, 1'b0);
        wait_drain("post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
